uart_crc_frame_tx: RTL

- Byte-stream-to-UART transmitter (8N1) that appends a CRC-8 trailer byte after every frame.
- Sits on the FPGA-to-PC side: upstream is the inter-FPGA receive path (data/valid), downstream is the PC serial line.
- Produces the frame format the PC-side and FPGA-side CRC checkers consume.
- Drives a running CRC and byte count for the 7-segment/LED debug display.

---
 rtl/uart_crc_frame_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_crc_frame_tx.sv
// rtl/uart_crc_frame_tx.sv - 8N1 UART transmitter that closes each frame with a CRC-8 trailer byte
module uart_crc_frame_tx #(
  parameter int FULL_BAUD = 2603,
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       db_reset,
  input  logic [7:0] i_8_data,
  input  logic       i_valid,
  input  logic       i_flush,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic [7:0] o_8_crc8,
  output logic [7:0] o_8_count,
  output logic       o_frame_done
);

  localparam int              BW         = (FULL_BAUD > 2) ? $clog2(FULL_BAUD) : 1;
  localparam logic [BW-1:0]   BAUD_LAST  = BW'(FULL_BAUD - 1);
  localparam logic [7:0]      LAST_COUNT = 8'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          is_crc;
  logic          baud_end;

  // CRC-8 poly 0x07, MSB first, one whole byte per call
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge db_reset) begin
    if (db_reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      is_crc       <= 1'b0;
      o_tx         <= 1'b1;
      o_ready      <= 1'b1;
      o_busy       <= 1'b0;
      o_8_crc8     <= 8'h00;
      o_8_count    <= 8'h00;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // data wins over flush when both are presented in the same cycle
          if (i_valid && o_ready) begin
            shreg     <= i_8_data;
            o_8_crc8  <= crc8_next(o_8_crc8, i_8_data);
            o_8_count <= o_8_count + 8'd1;
            state     <= START;
            baud_cnt  <= '0;
            o_tx      <= 1'b0;
            o_busy    <= 1'b1;
            o_ready   <= 1'b0;
          end else if (i_flush && (o_8_count != 8'h00)) begin
            shreg    <= o_8_crc8;
            is_crc   <= 1'b1;
            state    <= START;
            baud_cnt <= '0;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            o_ready  <= 1'b0;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            state    <= DATA;
            o_tx     <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              o_tx  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              o_tx    <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (is_crc) begin
              is_crc       <= 1'b0;
              o_8_crc8     <= 8'h00;
              o_8_count    <= 8'h00;
              o_frame_done <= 1'b1;
              state        <= IDLE;
              o_ready      <= 1'b1;
              o_busy       <= 1'b0;
            end else if (o_8_count == LAST_COUNT) begin
              // full frame: trailer starts with no idle gap
              shreg  <= o_8_crc8;
              is_crc <= 1'b1;
              state  <= START;
              o_tx   <= 1'b0;
            end else begin
              state   <= IDLE;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          o_tx    <= 1'b1;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
